// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mole_pkg
//  Description : Shared types, constants and hole-pick helper for the
//                whack-a-mole round sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mole_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPAWN = 3'd1,
        UP    = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int          NUM_HOLES = 9;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [6:0]  SCORE_MAX = 7'd99;

    // Folds a 4-bit random value onto 0..8 and steps past the previous hole
    // so the same hole never pops twice in a row.
    function automatic logic [3:0] pick_hole(input logic [3:0] raw, input logic [3:0] prev);
        logic [3:0] idx;
        idx = (raw >= 4'(NUM_HOLES)) ? raw - 4'(NUM_HOLES) : raw;
        if (idx == prev) begin
            idx = (idx == 4'(NUM_HOLES - 1)) ? 4'd0 : idx + 4'd1;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mole_round_sequencer_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import mole_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= {r_q[14:0], r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10]};
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/mole_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mole_round_sequencer
//  Description : Whack-a-mole round sequencer: mole scheduling, hit/miss
//                judging, scoring and the round countdown.
//  Revision    : 1.0 - initial release
// ============================================================================
module mole_round_sequencer
    import mole_pkg::*;
#(
    parameter int MS_CYCLES    = 100000,
    parameter int SEC_MS       = 1000,
    parameter int GAME_SECONDS = 30,
    parameter int GAP_MS       = 200,
    parameter int UP_MS0       = 1200,
    parameter int UP_MS1       = 900,
    parameter int UP_MS2       = 600,
    parameter int UP_MS3       = 400
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [1:0] difficulty,
    input  logic [8:0] tap,
    output logic [8:0] holes,
    output logic [6:0] score,
    output logic [4:0] time_left,
    output logic       busy,
    output logic       game_over,
    output logic       hit_pulse,
    output logic       miss_pulse
);

    localparam int c_PRE_W  = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam int c_SEC_W  = (SEC_MS > 1) ? $clog2(SEC_MS) : 1;
    localparam int c_M01    = (UP_MS0 > UP_MS1) ? UP_MS0 : UP_MS1;
    localparam int c_M23    = (UP_MS2 > UP_MS3) ? UP_MS2 : UP_MS3;
    localparam int c_MUP    = (c_M01 > c_M23) ? c_M01 : c_M23;
    localparam int c_MS_MAX = (c_MUP > GAP_MS) ? c_MUP : GAP_MS;
    localparam int c_MS_W   = $clog2(c_MS_MAX + 1);
    localparam logic [3:0] c_NO_HOLE = 4'hF;

    state_t              r_state, w_state_nxt;
    logic [8:0]          r_holes, w_holes_nxt;
    logic [6:0]          r_score, w_score_nxt;
    logic [4:0]          r_time_left, w_time_left_nxt;
    logic                r_game_over, w_game_over_nxt;
    logic                r_hit_pulse, w_hit_nxt;
    logic                r_miss_pulse, w_miss_nxt;
    logic                r_start_q;
    logic [8:0]          r_tap_q;
    logic [1:0]          r_diff, w_diff_nxt;
    logic [3:0]          r_idx, w_idx_nxt;
    logic [c_PRE_W-1:0]  r_pre, w_pre_nxt;
    logic [c_SEC_W-1:0]  r_sec, w_sec_nxt;
    logic [c_MS_W-1:0]   r_ms, w_ms_nxt;

    logic [15:0]         w_lfsr;
    logic                w_lfsr_unused;
    logic                w_start_edge;
    logic [8:0]          w_tap_edge;
    logic                w_run, w_ms_tick, w_sec_tick, w_expire;
    logic                w_hit, w_wrong;
    logic [3:0]          w_pick;
    logic [c_MS_W-1:0]   w_up_last;

    lfsr16 u_lfsr (
        .clk (clk),
        .clr (clr),
        .q   (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr[15:4];

    assign w_start_edge = start & ~r_start_q;
    assign w_tap_edge   = tap & ~r_tap_q;
    assign w_run        = (r_state == SPAWN) || (r_state == UP) || (r_state == GAP);
    assign w_ms_tick    = w_run && (r_pre == c_PRE_W'(MS_CYCLES - 1));
    assign w_sec_tick   = w_ms_tick && (r_sec == c_SEC_W'(SEC_MS - 1));
    assign w_expire     = w_sec_tick && (r_time_left == 5'd1);
    assign w_pick       = pick_hole(w_lfsr[3:0], r_idx);
    // In UP the hole register is exactly onehot(idx), so it doubles as the hit mask.
    assign w_hit        = (r_state == UP) && |(w_tap_edge & r_holes);
    assign w_wrong      = (r_state == UP) && |(w_tap_edge & ~r_holes);

    always_comb begin
        case (r_diff)
            2'd0:    w_up_last = c_MS_W'(UP_MS0 - 1);
            2'd1:    w_up_last = c_MS_W'(UP_MS1 - 1);
            2'd2:    w_up_last = c_MS_W'(UP_MS2 - 1);
            default: w_up_last = c_MS_W'(UP_MS3 - 1);
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_holes_nxt     = r_holes;
        w_score_nxt     = r_score;
        w_time_left_nxt = r_time_left;
        w_game_over_nxt = r_game_over;
        w_hit_nxt       = 1'b0;
        w_miss_nxt      = 1'b0;
        w_diff_nxt      = r_diff;
        w_idx_nxt       = r_idx;
        w_pre_nxt       = w_run ? (w_ms_tick ? '0 : r_pre + 1'b1) : r_pre;
        w_sec_nxt       = w_ms_tick ? (w_sec_tick ? '0 : r_sec + 1'b1) : r_sec;
        w_ms_nxt        = w_ms_tick ? r_ms + 1'b1 : r_ms;

        if (w_sec_tick) begin
            w_time_left_nxt = r_time_left - 5'd1;
        end

        case (r_state)
            IDLE, DONE: begin
                if (w_start_edge) begin
                    w_diff_nxt      = difficulty;
                    w_score_nxt     = '0;
                    w_time_left_nxt = 5'(GAME_SECONDS);
                    w_game_over_nxt = 1'b0;
                    w_holes_nxt     = '0;
                    w_pre_nxt       = '0;
                    w_sec_nxt       = '0;
                    w_ms_nxt        = '0;
                    w_state_nxt     = SPAWN;
                end
            end
            SPAWN: begin
                w_idx_nxt   = w_pick;
                w_holes_nxt = 9'b1 << w_pick;
                w_ms_nxt    = '0;
                w_state_nxt = UP;
            end
            UP: begin
                if (w_hit) begin
                    w_score_nxt = (r_score >= SCORE_MAX) ? SCORE_MAX : r_score + 7'd1;
                    w_hit_nxt   = 1'b1;
                    w_holes_nxt = '0;
                    w_ms_nxt    = '0;
                    w_state_nxt = GAP;
                end else begin
                    w_miss_nxt = w_wrong;
                    if (w_ms_tick && (r_ms == w_up_last)) begin
                        w_miss_nxt  = 1'b1;
                        w_holes_nxt = '0;
                        w_ms_nxt    = '0;
                        w_state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (w_ms_tick && (r_ms == c_MS_W'(GAP_MS - 1))) begin
                    w_state_nxt = SPAWN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Round expiry overrides the mole schedule but keeps any hit just scored.
        if (w_expire) begin
            w_state_nxt     = DONE;
            w_holes_nxt     = '0;
            w_game_over_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= IDLE;
            r_holes      <= '0;
            r_score      <= '0;
            r_time_left  <= 5'(GAME_SECONDS);
            r_game_over  <= 1'b0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_start_q    <= 1'b0;
            r_tap_q      <= '0;
            r_diff       <= '0;
            r_idx        <= c_NO_HOLE;
            r_pre        <= '0;
            r_sec        <= '0;
            r_ms         <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_holes      <= w_holes_nxt;
            r_score      <= w_score_nxt;
            r_time_left  <= w_time_left_nxt;
            r_game_over  <= w_game_over_nxt;
            r_hit_pulse  <= w_hit_nxt;
            r_miss_pulse <= w_miss_nxt;
            r_start_q    <= start;
            r_tap_q      <= tap;
            r_diff       <= w_diff_nxt;
            r_idx        <= w_idx_nxt;
            r_pre        <= w_pre_nxt;
            r_sec        <= w_sec_nxt;
            r_ms         <= w_ms_nxt;
        end
    end

    assign holes      = r_holes;
    assign score      = r_score;
    assign time_left  = r_time_left;
    assign busy       = w_run;
    assign game_over  = r_game_over;
    assign hit_pulse  = r_hit_pulse;
    assign miss_pulse = r_miss_pulse;

endmodule
`default_nettype wire

// File: tb/tb_mole_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mole_round_sequencer
//  Description : Directed, table-driven bench for mole_round_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_round_sequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic       start1, start2;
    logic [1:0] diff1, diff2;
    logic [8:0] tap1, tap2;
    logic [8:0] holes1, holes2;
    logic [6:0] score1, score2;
    logic [4:0] tl1, tl2;
    logic       busy1, busy2, go1, go2, hit1, hit2, miss1, miss2;

    always #5 clk = ~clk;

    mole_round_sequencer #(
        .MS_CYCLES(2), .SEC_MS(20), .GAME_SECONDS(3), .GAP_MS(2), .UP_MS3(4)
    ) u_dut1 (
        .clk(clk), .clr(clr), .start(start1), .difficulty(diff1), .tap(tap1),
        .holes(holes1), .score(score1), .time_left(tl1), .busy(busy1),
        .game_over(go1), .hit_pulse(hit1), .miss_pulse(miss1)
    );

    // Long round so the score can be driven to saturation.
    mole_round_sequencer #(
        .MS_CYCLES(2), .SEC_MS(20), .GAME_SECONDS(31), .GAP_MS(2), .UP_MS3(4)
    ) u_dut2 (
        .clk(clk), .clr(clr), .start(start2), .difficulty(diff2), .tap(tap2),
        .holes(holes2), .score(score2), .time_left(tl2), .busy(busy2),
        .game_over(go2), .hit_pulse(hit2), .miss_pulse(miss2)
    );

    // Reference LFSR; m_last is the value the DUT saw at the latest edge.
    logic [15:0] m_lfsr, m_last;
    always @(posedge clk) begin
        m_last <= m_lfsr;
        m_lfsr <= clr ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cur    = 15;

    typedef struct packed {
        logic       start;
        logic       busy;
        logic [1:0] hmode;   // 0: no mole, 1: new mole, 2: same mole
        logic       miss;
        logic [4:0] tl;
    } vec_t;
    vec_t vt [14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int predict(input logic [15:0] l, input int prev);
        int i;
        i = int'(l[3:0]);
        if (i >= 9) i = i - 9;
        if (i == prev) i = (i + 1) % 9;
        return i;
    endfunction

    task automatic wait_mole1(input string name);
        int n;
        int e;
        n = 0;
        while (holes1 == 9'd0 && n < 20) begin
            step();
            n++;
        end
        chk({name, " appears"}, int'(holes1 != 9'd0), 1);
        if (holes1 != 9'd0) begin
            e = predict(m_last, cur);
            chk({name, " hole"}, int'(holes1), 1 << e);
            cur = e;
        end
    endtask

    task automatic run_until(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        int c0, first_h, hits, misses, dbl, n;
        logic prev_hit;

        vt[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 5'd3};
        vt[1]  = '{1'b1, 1'b1, 2'd1, 1'b0, 5'd3};
        vt[2]  = '{1'b0, 1'b1, 2'd2, 1'b0, 5'd3};
        vt[3]  = '{1'b0, 1'b1, 2'd2, 1'b0, 5'd3};
        vt[4]  = '{1'b0, 1'b1, 2'd2, 1'b0, 5'd3};
        vt[5]  = '{1'b0, 1'b1, 2'd2, 1'b0, 5'd3};
        vt[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 5'd3};
        vt[7]  = '{1'b0, 1'b1, 2'd2, 1'b0, 5'd3};
        vt[8]  = '{1'b0, 1'b1, 2'd0, 1'b1, 5'd3};
        vt[9]  = '{1'b0, 1'b1, 2'd0, 1'b0, 5'd3};
        vt[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 5'd3};
        vt[11] = '{1'b0, 1'b1, 2'd0, 1'b0, 5'd3};
        vt[12] = '{1'b0, 1'b1, 2'd0, 1'b0, 5'd3};
        vt[13] = '{1'b0, 1'b1, 2'd1, 1'b0, 5'd3};

        clr = 1'b1; start1 = 1'b0; start2 = 1'b0;
        diff1 = 2'd3; diff2 = 2'd3; tap1 = '0; tap2 = '0;
        repeat (3) step();
        chk("rst holes", int'(holes1), 0);
        chk("rst score", int'(score1), 0);
        chk("rst time_left", int'(tl1), 3);
        chk("rst busy", int'(busy1), 0);
        chk("rst game_over", int'(go1), 0);
        chk("rst pulses", int'({hit1, miss1}), 0);
        clr = 1'b0;

        c0 = 0;
        first_h = 0;
        for (int k = 0; k < 14; k++) begin
            start1 = vt[k].start;
            step();
            if (k == 0) c0 = cyc;
            chk($sformatf("v%0d busy", k), int'(busy1), int'(vt[k].busy));
            chk($sformatf("v%0d miss", k), int'(miss1), int'(vt[k].miss));
            chk($sformatf("v%0d hit", k), int'(hit1), 0);
            chk($sformatf("v%0d time_left", k), int'(tl1), int'(vt[k].tl));
            case (vt[k].hmode)
                2'd0: chk($sformatf("v%0d holes", k), int'(holes1), 0);
                2'd1: begin
                    n = predict(m_last, cur);
                    chk($sformatf("v%0d new hole", k), int'(holes1), 1 << n);
                    cur = n;
                end
                default: chk($sformatf("v%0d held hole", k), int'(holes1), 1 << cur);
            endcase
            if (k == 1) first_h = int'(holes1);
        end
        chk("next hole differs", int'(int'(holes1) != first_h), 1);

        tap1 = 9'b1 << cur;
        step();
        chk("hit score", int'(score1), 1);
        chk("hit pulse", int'(hit1), 1);
        chk("hit holes", int'(holes1), 0);
        chk("hit no miss", int'(miss1), 0);
        tap1 = '0;
        step();
        chk("hit pulse width", int'(hit1), 0);

        wait_mole1("mole3");
        tap1 = (9'b1 << cur) | (9'b1 << ((cur + 1) % 9));
        step();
        chk("dual tap hit", int'(hit1), 1);
        chk("dual tap miss", int'(miss1), 0);
        chk("dual tap score", int'(score1), 2);
        tap1 = '0;
        step();

        wait_mole1("mole4");
        tap1 = 9'b1 << ((cur + 1) % 9);
        step();
        chk("wrong tap miss", int'(miss1), 1);
        chk("wrong tap holes", int'(holes1), 1 << cur);
        chk("wrong tap score", int'(score1), 2);
        step();
        chk("wrong held no miss", int'(miss1), 0);
        tap1 = tap1 | (9'b1 << cur);
        step();
        chk("late hit", int'(hit1), 1);
        chk("late hit score", int'(score1), 3);
        tap1 = '0;

        run_until(c0 + 39);
        chk("tl before 1st sec", int'(tl1), 3);
        step();
        chk("tl after 1st sec", int'(tl1), 2);
        run_until(c0 + 79);
        chk("tl before 2nd sec", int'(tl1), 2);
        step();
        chk("tl after 2nd sec", int'(tl1), 1);
        run_until(c0 + 119);
        chk("tl before end", int'(tl1), 1);
        chk("no early game_over", int'(go1), 0);
        step();
        chk("end time_left", int'(tl1), 0);
        chk("end game_over", int'(go1), 1);
        chk("end holes", int'(holes1), 0);
        chk("end busy", int'(busy1), 0);

        tap1 = 9'h1FF;
        step();
        chk("done tap score", int'(score1), 3);
        chk("done tap pulses", int'({hit1, miss1}), 0);
        tap1 = '0;
        start1 = 1'b1;
        step();
        chk("restart busy", int'(busy1), 1);
        chk("restart score", int'(score1), 0);
        chk("restart game_over", int'(go1), 0);
        chk("restart time_left", int'(tl1), 3);
        start1 = 1'b0;

        start2 = 1'b1;
        step();
        start2 = 1'b0;
        hits = 0; misses = 0; dbl = 0; prev_hit = 1'b0;
        for (int i = 0; i < 1200 && hits < 100; i++) begin
            tap2 = holes2;
            step();
            if (miss2) misses++;
            if (hit2 && prev_hit) dbl++;
            prev_hit = hit2;
            if (hit2) begin
                hits++;
                if (hits == 99) chk("score at 99 hits", int'(score2), 99);
                if (hits == 100) chk("score saturated", int'(score2), 99);
            end
        end
        chk("hundred hits reached", hits, 100);
        chk("no misses while tapping", misses, 0);
        chk("hit pulses single", dbl, 0);

        tap2 = '0;
        n = 0;
        while (holes2 == 9'd0 && n < 20) begin
            step();
            n++;
        end
        chk("mole before clr", int'(holes2 != 9'd0), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr holes", int'(holes2), 0);
        chk("clr score", int'(score2), 0);
        chk("clr time_left", int'(tl2), 31);
        chk("clr busy", int'(busy2), 0);
        chk("clr game_over", int'(go2), 0);
        chk("clr pulses", int'({hit2, miss2}), 0);
        chk("clr dut1 time_left", int'(tl1), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mole_round_sequencer.md
# mole_round_sequencer

Sequencer for the whack-a-mole game session. It turns a `start` button press into a timed round, pops one mole at a time on the 9 holes using a pseudo-random schedule, and applies the difficulty-dependent up-time. It also judges taps into hits and misses, keeps the score, and counts the round clock down. It sits between `fpga_test` (tap source, hole/score display) and `time_counter`/`music`, and owns all game sequencing.

## Interface
Parameters:
- `MS_CYCLES`, 100000: clk cycles per 1 ms tick.
- `SEC_MS`, 1000: ms ticks per round-second.
- `GAME_SECONDS`, 30: round length in seconds, at most 31.
- `GAP_MS`, 200: blank time between moles.
- `UP_MS0`/`UP_MS1`/`UP_MS2`/`UP_MS3`, 1200/900/600/400: mole up-time for difficulty 0..3.

Ports:
- `clk`  in  1: system clock.
- `clr`  in  1: reset. Synchronous, active-high; the only reset.
- `start`  in  1: start button, level. Acts on its rising edge.
- `difficulty`  in  2: sampled at round start.
- `tap`  in  9: one bit per hole, level. Acts on rising edges.
- `holes`  out  9: one-hot active mole, or all zero.
- `score`  out  7: hit count, saturates at 99.
- `time_left`  out  5: seconds remaining.
- `busy`  out  1: round in progress.
- `game_over`  out  1: round finished, score frozen.
- `hit_pulse`  out  1: one-cycle pulse on a hit.
- `miss_pulse`  out  1: one-cycle pulse on a miss.

## Operation
- Reset values: state IDLE, `holes`=0, `score`=0, `time_left`=`GAME_SECONDS`, `busy`=0, `game_over`=0, pulses 0, LFSR=16'hACE1, edge registers 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-running every cycle in every state.
- Edge detect: `start` and each `tap` bit are registered. An edge means current=1 and previous=0.
- IDLE: on a `start` edge, latch `difficulty`, set `score`=0, `time_left`=`GAME_SECONDS`, clear prescalers, go to SPAWN.
- SPAWN, one cycle:
  - Compute `idx`=`lfsr[3:0]`, minus 9 if it is ≥9.
  - If `idx` equals the previous hole, use (`idx`+1) mod 9.
  - Drive `holes`=onehot(`idx`), clear the ms counter, go to UP.
- UP:
  - Rising tap on `idx`: hit. `score`+1 (saturating at 99), `hit_pulse`, `holes`=0, go to GAP.
  - Rising tap on any other hole, with no hit that cycle: `miss_pulse`, stay in UP.
  - ms counter reaches `UP_MS[diff]`: `miss_pulse`, `holes`=0, go to GAP.
  - Hit wins over a wrong tap and over a timeout in the same cycle.
- GAP: `holes`=0 for `GAP_MS` ms ticks, then go to SPAWN. Taps are ignored.
- Round clock: runs in SPAWN, UP and GAP.
  - The ms prescaler wraps at `MS_CYCLES`-1 and emits a tick.
  - The second counter wraps at `SEC_MS`-1 and decrements `time_left`.
  - When `time_left` becomes 0: go to DONE, `holes`=0, `game_over`=1. A hit in that same cycle is still scored.
- DONE: `score` frozen, `time_left`=0. A `start` edge behaves as in IDLE and clears `game_over`.
- `start` edges during play are ignored. `clr` mid-round returns every output to its reset value next cycle.
- `busy`=1 in SPAWN, UP and GAP.

## Timing
- `start` edge at cycle N: `busy`=1 at N+1, `holes` nonzero at N+2.
- Tap edge at cycle N in UP: `score`, `hit_pulse` and `holes`=0 all at N+1.
- Timeout: `holes` drop the cycle after the `UP_MS[diff]`-th ms tick since SPAWN.
- `time_left` updates the cycle after the second boundary.
- Pulses are exactly 1 cycle. `holes` is never multi-hot.

## Structure
- Package `mole_pkg`: `state_t` (IDLE, SPAWN, UP, GAP, DONE), `NUM_HOLES`=9, `LFSR_SEED`=16'hACE1, `SCORE_MAX`=99.
- Sub-module `lfsr16` (clk, clr, q[15:0]), free-running.
- Everything else is flat: FSM, prescalers, edge detect, hole pick.

## Test plan
Bench settings: `MS_CYCLES`=2, `SEC_MS`=20, `GAME_SECONDS`=3, `GAP_MS`=2, `UP_MS3`=4.
- Reset: hold `clr` 3 cycles. Expect `holes`=0, `score`=0, `time_left`=3, `busy`=0, `game_over`=0.
- Start, difficulty=3, no taps: `holes` one-hot at N+2. The mole drops after 4 ms ticks (8 cycles) with one `miss_pulse`. After 2 gap ticks a new hole appears that differs from the previous one.
- Correct tap in UP: `score` 0→1, `hit_pulse` for 1 cycle, `holes`=0 the next cycle.
- Wrong-hole tap, then correct-hole tap in the same cycle: `hit_pulse`=1, `miss_pulse`=0, `score`+1.
- Round expiry: `time_left` steps 3→2→1→0 every 40 cycles. At 0 expect `game_over`=1, `holes`=0, `busy`=0. A further tap leaves `score` unchanged. A new `start` edge restarts with `score`=0.
- Force `score`=99 by hits: one more hit keeps `score`=99. Asserting `clr` mid-UP gives all reset values the next cycle.
